// File: rtl/mem_responder_if.sv
// MAR/MDR memory bus between the control sequencer and mem_responder.
interface mem_responder_if;
  logic        RAMenable;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output RAMenable, read, write, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  RAMenable, read, write, addr, wdata,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word RAM responder for the MAR/MDR bus.
// MEM_RESPONDER_BOUNDS_CHECK_EN rejects addresses beyond DEPTH.
module mem_responder #(
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clock,
  input  logic          clear,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  logic [31:0]       mem [DEPTH];

  state_t            state;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              wr_q;
  logic [31:0]       rdata_q;
  logic              ready_q;
  logic              busy_q;
  logic              err_q;

  logic req;
  logic conflict;
  logic oob;

  assign req      = bus.RAMenable & (bus.read ^ bus.write);
  assign conflict = bus.RAMenable & bus.read & bus.write;

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
  assign oob = |bus.addr[31:ADDR_W];
`else
  logic unused_hi;
  assign oob       = 1'b0;
  assign unused_hi = ^bus.addr[31:ADDR_W];
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (conflict || (req && oob)) begin
            err_q <= 1'b1;
          end else if (req) begin
            idx_q   <= bus.addr[ADDR_W-1:0];
            wdata_q <= bus.wdata;
            wr_q    <= bus.write;
            cnt_q   <= WC;
            busy_q  <= 1'b1;
            state   <= (WC != 4'd0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state <= ACCESS;
        end
        ACCESS: begin
          if (!wr_q) rdata_q <= mem[idx_q];
          ready_q <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Storage is never reset; a clear before ACCESS drops the write.
  always_ff @(posedge clock) begin
    if (!clear && state == ACCESS && wr_q) mem[idx_q] <= wdata_q;
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (WAIT_CYCLES=1).
// Bounds expectations follow MEM_RESPONDER_BOUNDS_CHECK_EN.
module tb_mem_responder;

  logic clock;
  logic clear;
  int   checks;
  int   passed;

  mem_responder_if bus ();

  mem_responder dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_bus;
    bus.RAMenable = 1'b0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
  endtask

  task automatic req(input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.RAMenable = 1'b1;
    bus.read      = rd;
    bus.write     = wr;
    bus.addr      = a;
    bus.wdata     = d;
    @(posedge clock);
    #1 idle_bus();
  endtask

  // Index i is the falling edge after capture edge N+i.
  task automatic watch(input int n, output int first, output int pulses,
                       output int idle_at, output int errs);
    first   = -1;
    pulses  = 0;
    idle_at = -1;
    errs    = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (bus.ready) begin
        if (first < 0) first = i;
        pulses++;
      end
      if (!bus.busy && idle_at < 0) idle_at = i;
      if (bus.err) errs++;
    end
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d);
    int f, p, il, e;
    req(1'b0, 1'b1, a, d);
    watch(5, f, p, il, e);
  endtask

  task automatic get(input logic [31:0] a);
    int f, p, il, e;
    req(1'b1, 1'b0, a, '0);
    watch(5, f, p, il, e);
  endtask

  task automatic test_reset;
    clear = 1'b1;
    idle_bus();
    #1;
    checks++;
    if (bus.rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", bus.rdata);
    else passed++;
    checks++;
    if (bus.ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.ready);
    else passed++;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy);
    else passed++;
    checks++;
    if (bus.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err);
    else passed++;
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_write_read;
    int f, p, il, e;
    req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    watch(6, f, p, il, e);
    checks++;
    if (f !== 2) $display("FAIL wr_ready_at got %0d want 2", f);
    else passed++;
    checks++;
    if (p !== 1) $display("FAIL wr_pulses got %0d want 1", p);
    else passed++;
    checks++;
    if (il !== 3) $display("FAIL wr_busy_fall got %0d want 3", il);
    else passed++;
    checks++;
    if (bus.rdata !== 32'h0) $display("FAIL wr_rdata_kept got %h want 0", bus.rdata);
    else passed++;
    req(1'b1, 1'b0, 32'h10, 32'h0);
    watch(6, f, p, il, e);
    checks++;
    if (f !== 2) $display("FAIL rd_ready_at got %0d want 2", f);
    else passed++;
    checks++;
    if (bus.rdata !== 32'hDEADBEEF) $display("FAIL rd_data got %h want deadbeef", bus.rdata);
    else passed++;
  endtask

  task automatic test_strobe_dropout;
    int f, p, il, e;
    put(32'h07, 32'hCAFEF00D);
    @(negedge clock);
    bus.RAMenable = 1'b1;
    bus.read      = 1'b1;
    bus.addr      = 32'h07;
    @(posedge clock);
    fork
      begin
        #15 idle_bus();
      end
    join_none
    watch(7, f, p, il, e);
    checks++;
    if (p !== 1) $display("FAIL drop_pulses got %0d want 1", p);
    else passed++;
    checks++;
    if (bus.rdata !== 32'hCAFEF00D) $display("FAIL drop_rdata got %h want cafef00d", bus.rdata);
    else passed++;
  endtask

  task automatic test_busy_ignore;
    int f, p, il, e;
    put(32'h20, 32'h20202020);
    req(1'b1, 1'b0, 32'h10, 32'h0);
    fork
      begin
        @(negedge clock);
        bus.RAMenable = 1'b1;
        bus.read      = 1'b1;
        bus.addr      = 32'h20;
        @(negedge clock);
        idle_bus();
      end
    join_none
    watch(8, f, p, il, e);
    checks++;
    if (p !== 1) $display("FAIL busy_pulses got %0d want 1", p);
    else passed++;
    checks++;
    if (bus.rdata !== 32'hDEADBEEF) $display("FAIL busy_rdata got %h want deadbeef", bus.rdata);
    else passed++;
  endtask

  task automatic test_conflict;
    int f, p, il, e;
    put(32'h30, 32'h11111111);
    req(1'b1, 1'b1, 32'h30, 32'hFFFFFFFF);
    @(negedge clock);
    checks++;
    if (bus.err !== 1'b1) $display("FAIL conf_err got %b want 1", bus.err);
    else passed++;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL conf_busy got %b want 0", bus.busy);
    else passed++;
    watch(3, f, p, il, e);
    checks++;
    if (e !== 0 || p !== 0) $display("FAIL conf_after got err=%0d rdy=%0d want 0 0", e, p);
    else passed++;
    req(1'b1, 1'b0, 32'h30, 32'h0);
    watch(5, f, p, il, e);
    checks++;
    if (bus.rdata !== 32'h11111111) $display("FAIL conf_mem got %h want 11111111", bus.rdata);
    else passed++;
  endtask

  task automatic test_noop;
    int f, p, il, e;
    @(negedge clock);
    bus.RAMenable = 1'b1;
    bus.addr      = 32'h10;
    watch(3, f, p, il, e);
    idle_bus();
    bus.read = 1'b1;
    watch(3, f, p, il, e);
    idle_bus();
    checks++;
    if (il !== 0 || p !== 0) $display("FAIL noop_busy got idle=%0d rdy=%0d want 0 0", il, p);
    else passed++;
    checks++;
    if (e !== 0) $display("FAIL noop_err got %0d want 0", e);
    else passed++;
  endtask

  task automatic test_reset_mid_write;
    int f, p, il, e;
    put(32'h05, 32'h0BADF00D);
    get(32'h05);
    req(1'b0, 1'b1, 32'h05, 32'h12345678);
    @(negedge clock);
    clear = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL clr_busy got %b want 0", bus.busy);
    else passed++;
    checks++;
    if (bus.rdata !== 32'h0) $display("FAIL clr_rdata got %h want 0", bus.rdata);
    else passed++;
    checks++;
    if (bus.ready !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL clr_flags got rdy=%b err=%b want 0 0", bus.ready, bus.err);
    else passed++;
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;
    req(1'b1, 1'b0, 32'h05, 32'h0);
    watch(5, f, p, il, e);
    checks++;
    if (bus.rdata !== 32'h0BADF00D) $display("FAIL clr_mem got %h want 0badf00d", bus.rdata);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int f, p, il, e;
    @(negedge clock);
    bus.RAMenable = 1'b1;
    bus.read      = 1'b1;
    bus.addr      = 32'h07;
    @(posedge clock);
    watch(11, f, p, il, e);
    idle_bus();
    checks++;
    if (p !== 3) $display("FAIL b2b_pulses got %0d want 3", p);
    else passed++;
    checks++;
    if (f !== 2) $display("FAIL b2b_first got %0d want 2", f);
    else passed++;
    watch(4, f, p, il, e);
  endtask

  task automatic test_bounds;
    int f, p, il, e;
    put(32'h00, 32'hA5A5A5A5);
    get(32'h10);
    req(1'b1, 1'b0, 32'h200, 32'h0);
    watch(6, f, p, il, e);
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    checks++;
    if (e !== 1) $display("FAIL oob_err got %0d want 1", e);
    else passed++;
    checks++;
    if (p !== 0) $display("FAIL oob_ready got %0d want 0", p);
    else passed++;
    checks++;
    if (bus.rdata !== 32'hDEADBEEF) $display("FAIL oob_rdata got %h want deadbeef", bus.rdata);
    else passed++;
`else
    checks++;
    if (e !== 0) $display("FAIL alias_err got %0d want 0", e);
    else passed++;
    checks++;
    if (f !== 2) $display("FAIL alias_ready got %0d want 2", f);
    else passed++;
    checks++;
    if (bus.rdata !== 32'hA5A5A5A5) $display("FAIL alias_rdata got %h want a5a5a5a5", bus.rdata);
    else passed++;
`endif
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_write_read();
    test_strobe_dropout();
    test_busy_ignore();
    test_conflict();
    test_noop();
    test_reset_mid_write();
    test_back_to_back();
    test_bounds();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
